// File: rtl/barrel_shift_sequencer.sv
// Multi-cycle left rotate / logical-shift sequencer: one power-of-two stage per clock,
// LSB stage first, all stages always run so latency never depends on the amount.
module barrel_shift_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   IVALID,
    output logic                   IREADY,
    input  logic [DATA_WIDTH-1:0]  IDATA,
    input  logic [SHAMT_WIDTH-1:0] ISHAMT,
    input  logic                   IMODE,
    output logic                   OVALID,
    input  logic                   OREADY,
    output logic [DATA_WIDTH-1:0]  ODATA,
    output logic                   BUSY
);

    localparam int KW = $clog2(SHAMT_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [DATA_WIDTH-1:0]  w_data_nxt;
    logic [SHAMT_WIDTH-1:0] r_amt;
    logic [SHAMT_WIDTH-1:0] w_amt_nxt;
    logic                   r_mode;
    logic                   w_mode_nxt;
    logic [KW-1:0]          r_k;
    logic [KW-1:0]          w_k_nxt;

    logic [DATA_WIDTH-1:0]  w_stage [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0]  w_stage_out;
    logic                   w_stage_en;

    // Fixed-distance wirings, one per stage; only one is selected per cycle.
    for (genvar g = 0; g < SHAMT_WIDTH; g++) begin : g_stage
        localparam int S = 2 ** g;
        assign w_stage[g] = r_mode ? {r_data[DATA_WIDTH-1-S:0], {S{1'b0}}}
                                   : {r_data[DATA_WIDTH-1-S:0], r_data[DATA_WIDTH-1:DATA_WIDTH-S]};
    end

    // Pick the stage wiring and its amount bit for the current stage index.
    always_comb begin
        w_stage_out = r_data;
        w_stage_en  = 1'b0;
        for (int k = 0; k < SHAMT_WIDTH; k++) begin
            if (r_k == KW'(k)) begin
                w_stage_out = w_stage[k];
                w_stage_en  = r_amt[k];
            end else begin
                w_stage_out = w_stage_out;
                w_stage_en  = w_stage_en;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_amt_nxt   = r_amt;
        w_mode_nxt  = r_mode;
        w_k_nxt     = r_k;
        case (r_state)
            ST_IDLE: begin
                if (IVALID) begin
                    w_data_nxt  = IDATA;
                    w_amt_nxt   = ISHAMT;
                    w_mode_nxt  = IMODE;
                    w_k_nxt     = {KW{1'b0}};
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_stage_en) begin
                    w_data_nxt = w_stage_out;
                end else begin
                    w_data_nxt = r_data;
                end
                w_k_nxt = r_k + KW'(1);
                if (r_k == KW'(SHAMT_WIDTH - 1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (OREADY) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_data  <= {DATA_WIDTH{1'b0}};
            r_amt   <= {SHAMT_WIDTH{1'b0}};
            r_mode  <= 1'b0;
            r_k     <= {KW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_amt   <= w_amt_nxt;
            r_mode  <= w_mode_nxt;
            r_k     <= w_k_nxt;
        end
    end

    assign IREADY = (r_state == ST_IDLE);
    assign OVALID = (r_state == ST_DONE);
    assign BUSY   = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign ODATA  = r_data;

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Scoreboard bench for barrel_shift_sequencer: driver pushes expected results,
// a negedge monitor pops and compares them when results are presented.
module tb_barrel_shift_sequencer;

    localparam int DW  = 32;
    localparam int SW  = 5;
    localparam int LAT = SW;
    localparam int PER = SW + 2;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          IVALID;
    logic          IREADY;
    logic [DW-1:0] IDATA;
    logic [SW-1:0] ISHAMT;
    logic          IMODE;
    logic          OVALID;
    logic          OREADY;
    logic [DW-1:0] ODATA;
    logic          BUSY;

    barrel_shift_sequencer #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .CLK(CLK), .RST_N(RST_N), .IVALID(IVALID), .IREADY(IREADY),
        .IDATA(IDATA), .ISHAMT(ISHAMT), .IMODE(IMODE), .OVALID(OVALID),
        .OREADY(OREADY), .ODATA(ODATA), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            ordy_mode = 0;
    bit            hold_valid = 1'b0;
    bit            b2b = 1'b0;
    bit            have_last = 1'b0;
    int            last_acc = 0;
    logic          prev_ov = 1'b0;
    logic [DW-1:0] last_res = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Rotate = upper half of the doubled word shifted; logical = plain shift.
    function automatic logic [DW-1:0] ref_model(input logic [DW-1:0] d, input int a, input bit m);
        logic [2*DW-1:0] t;
        t = {d, d} << a;
        if (m) return d << a;
        return t[2*DW-1:DW];
    endfunction

    task automatic send(input logic [DW-1:0] d, input int a, input bit m, input logic [DW-1:0] exp);
        bit ok;
        ok = 1'b0;
        IDATA  = d;
        ISHAMT = 5'(a);
        IMODE  = m;
        IVALID = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (IREADY) ok = 1'b1;
        end
        if (!ok) begin
            chk("accept_timeout", 32'(IREADY), 32'd1);
            IVALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        sb.push_back('{exp, cyc});
        if (b2b && have_last) chk("b2b_spacing", 32'(cyc - last_acc), 32'(PER));
        last_acc  = cyc;
        have_last = 1'b1;
        if (!hold_valid) begin
            IVALID = 1'b0;
            IDATA  = $urandom;
            ISHAMT = 5'($urandom_range(0, 31));
            IMODE  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(posedge CLK);
        if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        #1;
    endtask

    // Consumer: OREADY random, forced high or forced low.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (ordy_mode)
                0:       OREADY = 1'($urandom_range(0, 1));
                1:       OREADY = 1'b1;
                default: OREADY = 1'b0;
            endcase
        end
    end

    // Monitor: retires a result when OVALID falls, checks data/latency while it is high.
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_ov  = 1'b0;
            last_res = '0;
        end else begin
            if (prev_ov && !OVALID && sb.size() > 0) begin
                last_res = sb[0].data;
                void'(sb.pop_front());
            end
            if (OVALID && sb.size() == 0) chk("ovalid_without_request", 32'(OVALID), 32'd0);
            if (OVALID && sb.size() > 0) begin
                if (!prev_ov) chk("latency", 32'(cyc - sb[0].acc), 32'(LAT));
                chk("odata", ODATA, sb[0].data);
            end
            if (sb.size() > 0) begin
                chk("busy_in_flight", 32'(BUSY), 32'd1);
                chk("iready_in_flight", 32'(IREADY), 32'd0);
            end else begin
                chk("idle_flags", 32'({IREADY, BUSY, OVALID}), 32'b100);
                chk("idle_odata_holds", ODATA, last_res);
            end
            prev_ov = OVALID;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        RST_N  = 1'b0;
        IVALID = 1'b0;
        IDATA  = '0;
        ISHAMT = '0;
        IMODE  = 1'b0;
        OREADY = 1'b0;
        @(negedge CLK);
        chk("reset_iready", 32'(IREADY), 32'd1);
        chk("reset_ovalid", 32'(OVALID), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_odata", ODATA, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Directed cases with hand-computed expectations.
        send(32'h8000_0001, 1, 1'b0, 32'h0000_0003);
        send(32'h8000_0001, 4, 1'b1, 32'h0000_0010);
        send(32'h1234_5678, 8, 1'b0, 32'h3456_7812);
        send(32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF);
        send(32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF);
        send(32'hFFFF_FFFF, 31, 1'b1, 32'h8000_0000);
        send(32'h0000_0003, 31, 1'b0, 32'h8000_0001);

        // Sweep every amount in both modes with random operands.
        for (int a = 0; a < DW; a++) begin
            for (int m = 0; m < 2; m++) begin
                d = $urandom;
                send(d, a, 1'(m), ref_model(d, a, 1'(m)));
            end
        end
        wait_drain();

        // Backpressure: result must hold while OREADY is low; new requests ignored.
        ordy_mode = 2;
        d = $urandom;
        send(d, 13, 1'b0, ref_model(d, 13, 1'b0));
        for (int i = 0; i < 40 && !OVALID; i++) @(negedge CLK);
        chk("bp_ovalid_seen", 32'(OVALID), 32'd1);
        #1;
        IVALID = 1'b1;
        IDATA  = $urandom;
        ISHAMT = 5'd7;
        IMODE  = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("bp_ovalid_hold", 32'(OVALID), 32'd1);
            chk("bp_iready_low", 32'(IREADY), 32'd0);
        end
        #1;
        IVALID    = 1'b0;
        ordy_mode = 1;
        OREADY    = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_release_idle", 32'(IREADY), 32'd1);
        chk("bp_release_ovalid", 32'(OVALID), 32'd0);
        wait_drain();

        // Back-to-back with IVALID held and OREADY high.
        b2b        = 1'b1;
        have_last  = 1'b0;
        hold_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int a;
            bit m;
            d = $urandom;
            a = $urandom_range(0, 31);
            m = 1'($urandom_range(0, 1));
            send(d, a, m, ref_model(d, a, m));
        end
        IVALID     = 1'b0;
        hold_valid = 1'b0;
        b2b        = 1'b0;
        wait_drain();

        // Reset during the third SHIFT cycle aborts the operation.
        send(32'hCAFE_F00D, 3, 1'b0, ref_model(32'hCAFE_F00D, 3, 1'b0));
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        sb.delete();
        #1;
        chk("midrst_iready", 32'(IREADY), 32'd1);
        chk("midrst_ovalid", 32'(OVALID), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_odata", ODATA, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        ordy_mode = 0;
        d = $urandom;
        send(d, 21, 1'b1, ref_model(d, 21, 1'b1));
        d = $urandom;
        send(d, 17, 1'b0, ref_model(d, 17, 1'b0));
        wait_drain();
        repeat (5) @(posedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
